// File: rtl/symbiface_mouse_acc_pkg.sv
// SYMBiFACE II mouse port: shared record tags, kind encoding and clamps.
// Imported by the accumulating mouse port and its testbench.
package symbiface_pkg;

    typedef enum logic [2:0] {
        KIND_X    = 3'd0,
        KIND_Y    = 3'd1,
        KIND_BTN  = 3'd2,
        KIND_WHL  = 3'd3,
        KIND_NONE = 3'd4
    } kind_e;

    localparam logic [1:0] TAG_X    = 2'b01;
    localparam logic [1:0] TAG_Y    = 2'b10;
    localparam logic [2:0] TAG_BTN  = 3'b110;
    localparam logic [3:0] TAG_WHL  = 4'b1110;
    localparam logic [7:0] TAG_NONE = 8'h00;

    function automatic logic signed [5:0] clamp6(input logic signed [15:0] v);
        if (v > 16'sd31)
            return 6'b011111;
        else if (v < -16'sd32)
            return 6'b100000;
        else
            return v[5:0];
    endfunction

    function automatic logic signed [3:0] clamp4(input logic signed [15:0] v);
        if (v > 16'sd7)
            return 4'b0111;
        else if (v < -16'sd8)
            return 4'b1000;
        else
            return v[3:0];
    endfunction

endpackage

// File: rtl/symbiface_mouse_acc_if.sv
// Mouse port bus: hps_io PS/2 mouse/wheel inputs plus the CPU read side.
// master drives packets and the read strobe, slave returns read data.
interface symbiface_mouse_acc_if;
    logic [24:0] ps2_mouse;
    logic [7:0]  ps2_wheel;
    logic        sel;
    logic [7:0]  dout;

    modport master (
        output ps2_mouse,
        output ps2_wheel,
        output sel,
        input  dout
    );

    modport slave (
        input  ps2_mouse,
        input  ps2_wheel,
        input  sel,
        output dout
    );
endinterface

// File: rtl/symbiface_mouse_acc_sat_acc.sv
// Saturating signed accumulator: q <= sat_W(q - sub + add) at full precision.
// NEG=1 accumulates the negated add operand without 9-bit overflow.
module sat_acc #(
    parameter int W   = 12,
    parameter bit NEG = 1'b0
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic signed [8:0]   add,
    input  logic signed [6:0]   sub,
    input  logic                en_add,
    input  logic                en_sub,
    output logic signed [W-1:0] q
);

    // 18 bits hold any 16-bit accumulator plus both operands without wrap
    localparam logic signed [17:0] MAXV = 18'((1 << (W - 1)) - 1);
    localparam logic signed [17:0] MINV = -MAXV - 18'sd1;

    logic signed [17:0] sum;

    always_comb begin
        sum = 18'(q);
        if (en_sub)
            sum = sum - 18'(sub);
        if (en_add) begin
            if (NEG)
                sum = sum - 18'(add);
            else
                sum = sum + 18'(add);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            q <= '0;
        else if (sum > MAXV)
            q <= MAXV[W-1:0];
        else if (sum < MINV)
            q <= MINV[W-1:0];
        else
            q <= sum[W-1:0];
    end

endmodule

// File: rtl/symbiface_mouse_acc.sv
// SYMBiFACE II PS/2 mouse port with saturating motion accumulation
// and round-robin X/Y/button/wheel reporting, one byte per CPU read.
module symbiface_mouse_acc
    import symbiface_pkg::*;
#(
    parameter int ACC_W    = 12,
    parameter int WHL_W    = 8,
    parameter bit WHEEL    = 1'b1,
    parameter bit INVERT_Y = 1'b0
) (
    input logic                  clk_sys,
    input logic                  reset,
    symbiface_mouse_acc_if.slave bus
);

    logic                    tog_q;
    logic                    sel_q;
    logic                    pkt;
    logic                    start;
    logic                    retire;
    logic signed [8:0]       dx;
    logic signed [8:0]       dy;
    logic signed [8:0]       dw;
    logic [2:0]              btn;
    logic [2:0]              btn_last;
    logic                    btn_pend;
    logic signed [ACC_W-1:0] acc_x;
    logic signed [ACC_W-1:0] acc_y;
    logic signed [WHL_W-1:0] acc_w;
    logic signed [15:0]      ax16;
    logic signed [15:0]      ay16;
    logic signed [15:0]      aw16;
    logic signed [5:0]       ex;
    logic signed [5:0]       ey;
    logic signed [3:0]       ew;
    logic [1:0]              ptr;
    logic [1:0]              idx;
    logic [3:0]              cand;
    kind_e                   pick;
    kind_e                   sel_kind;
    logic signed [6:0]       val;
    logic signed [6:0]       sel_val;
    logic [7:0]              rec;
    logic [7:0]              dout_q;
    logic                    unused;

    assign pkt    = bus.ps2_mouse[24] ^ tog_q;
    assign start  = bus.sel & ~sel_q;
    assign retire = ~bus.sel & sel_q;
    assign dx     = {bus.ps2_mouse[4], bus.ps2_mouse[15:8]};
    assign dy     = {bus.ps2_mouse[5], bus.ps2_mouse[23:16]};
    assign dw     = {bus.ps2_wheel[7], bus.ps2_wheel};
    assign btn    = bus.ps2_mouse[2:0];
    assign unused = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3], dw};

    sat_acc #(.W(ACC_W), .NEG(1'b0)) u_x (
        .clk_sys (clk_sys),
        .reset   (reset),
        .add     (dx),
        .sub     (sel_val),
        .en_add  (pkt),
        .en_sub  (retire && sel_kind == KIND_X),
        .q       (acc_x)
    );

    sat_acc #(.W(ACC_W), .NEG(INVERT_Y)) u_y (
        .clk_sys (clk_sys),
        .reset   (reset),
        .add     (dy),
        .sub     (sel_val),
        .en_add  (pkt),
        .en_sub  (retire && sel_kind == KIND_Y),
        .q       (acc_y)
    );

    if (WHEEL) begin : g_whl
        sat_acc #(.W(WHL_W), .NEG(1'b0)) u_w (
            .clk_sys (clk_sys),
            .reset   (reset),
            .add     (dw),
            .sub     (sel_val),
            .en_add  (pkt),
            .en_sub  (retire && sel_kind == KIND_WHL),
            .q       (acc_w)
        );
    end else begin : g_nowhl
        assign acc_w = '0;
    end

    assign ax16 = acc_x;
    assign ay16 = acc_y;
    assign aw16 = acc_w;
    assign ex   = clamp6(ax16);
    assign ey   = clamp6(ay16);
    assign ew   = clamp4(aw16);

    assign cand = {WHEEL && acc_w != '0, btn_pend,
                   acc_y != '0, acc_x != '0};

    // Walk backwards so the candidate nearest ptr wins
    always_comb begin
        pick = KIND_NONE;
        idx  = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (cand[idx])
                pick = kind_e'({1'b0, idx});
        end
    end

    always_comb begin
        rec = TAG_NONE;
        val = '0;
        unique case (pick)
            KIND_X: begin
                rec = {TAG_X, ex};
                val = {ex[5], ex};
            end
            KIND_Y: begin
                rec = {TAG_Y, ey};
                val = {ey[5], ey};
            end
            KIND_BTN: rec = {TAG_BTN, 2'b00, btn_last};
            KIND_WHL: begin
                rec = {TAG_WHL, ew};
                val = {{3{ew[3]}}, ew};
            end
            default: begin
                rec = TAG_NONE;
                val = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        tog_q <= bus.ps2_mouse[24];
        sel_q <= bus.sel;
        if (reset) begin
            btn_last <= '0;
            btn_pend <= 1'b0;
            ptr      <= 2'd0;
            sel_kind <= KIND_NONE;
            sel_val  <= '0;
            dout_q   <= 8'hFF;
        end else begin
            if (pkt)
                btn_last <= btn;
            // A fresh button change survives a retiring button read
            btn_pend <= (pkt && btn != btn_last)
                     || (btn_pend && !(retire && sel_kind == KIND_BTN));
            if (!bus.sel)
                dout_q <= 8'hFF;
            else if (start)
                dout_q <= rec;
            if (start) begin
                sel_kind <= pick;
                sel_val  <= val;
            end else if (retire) begin
                if (sel_kind != KIND_NONE)
                    ptr <= sel_kind[1:0] + 2'd1;
                sel_kind <= KIND_NONE;
            end
        end
    end

    assign bus.dout = dout_q;

endmodule

// File: tb/tb_symbiface_mouse_acc.sv
// Bench for symbiface_mouse_acc: a default instance and a narrow
// (ACC_W=9, WHL_W=5, no wheel) instance driven in lockstep vs. a model.
module tb_symbiface_mouse_acc;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic tog     = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    symbiface_mouse_acc_if b0 ();
    symbiface_mouse_acc_if b1 ();

    symbiface_mouse_acc #(
        .ACC_W(12), .WHL_W(8), .WHEEL(1'b1), .INVERT_Y(1'b0)
    ) d0 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (b0.slave)
    );

    symbiface_mouse_acc #(
        .ACC_W(9), .WHL_W(5), .WHEEL(1'b0), .INVERT_Y(1'b0)
    ) d1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (b1.slave)
    );

    // Reference model: per-instance motion totals and a report cursor
    int accw[2] = '{12, 9};
    int whlw[2] = '{8, 5};
    int whe[2]  = '{1, 0};
    int m_x[2], m_y[2], m_w[2], m_bl[2], m_bp[2];
    int m_ptr[2], m_kind[2], m_val[2];

    function automatic int sat(int v, int w);
        int lo = -(1 << (w - 1));
        int hi = (1 << (w - 1)) - 1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic int clampi(int v, int lo, int hi);
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_x[d] = 0; m_y[d] = 0; m_w[d] = 0;
            m_bl[d] = 0; m_bp[d] = 0;
            m_ptr[d] = 0; m_kind[d] = 4; m_val[d] = 0;
        end
    endfunction

    function automatic void model_pkt(int d, int dx, int dy, int b, int w);
        m_x[d] = sat(m_x[d] + dx, accw[d]);
        m_y[d] = sat(m_y[d] + dy, accw[d]);
        if (whe[d] != 0)
            m_w[d] = sat(m_w[d] + w, whlw[d]);
        if (b != m_bl[d])
            m_bp[d] = 1;
        m_bl[d] = b;
    endfunction

    function automatic int model_start(int d);
        for (int i = 0; i < 4; i++) begin
            int k = (m_ptr[d] + i) % 4;
            m_kind[d] = k;
            if (k == 0 && m_x[d] != 0) begin
                m_val[d] = clampi(m_x[d], -32, 31);
                return 64 + (m_val[d] & 63);
            end
            if (k == 1 && m_y[d] != 0) begin
                m_val[d] = clampi(m_y[d], -32, 31);
                return 128 + (m_val[d] & 63);
            end
            if (k == 2 && m_bp[d] != 0) begin
                m_val[d] = 0;
                return 192 + m_bl[d];
            end
            if (k == 3 && whe[d] != 0 && m_w[d] != 0) begin
                m_val[d] = clampi(m_w[d], -8, 7);
                return 224 + (m_val[d] & 15);
            end
        end
        m_kind[d] = 4;
        m_val[d]  = 0;
        return 0;
    endfunction

    function automatic void model_retire(int d);
        case (m_kind[d])
            0: m_x[d] = sat(m_x[d] - m_val[d], accw[d]);
            1: m_y[d] = sat(m_y[d] - m_val[d], accw[d]);
            2: m_bp[d] = 0;
            3: m_w[d] = sat(m_w[d] - m_val[d], whlw[d]);
            default: ;
        endcase
        if (m_kind[d] < 4)
            m_ptr[d] = (m_kind[d] + 1) % 4;
        m_kind[d] = 4;
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_sel(logic s);
        b0.sel = s;
        b1.sel = s;
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        set_sel(1'b0);
        @(posedge clk_sys);
        #1;
        model_reset();
        chk("rst_d0", b0.dout, 8'hFF);
        chk("rst_d1", b1.dout, 8'hFF);
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic packet(int dx, int dy, int b, int w);
        logic [7:0] xl, yl, wl;
        logic [24:0] pm;
        xl = dx[7:0];
        yl = dy[7:0];
        wl = w[7:0];
        @(negedge clk_sys);
        tog = ~tog;
        pm = {tog, yl, xl, 2'b00, dy < 0, dx < 0, 1'b0, 3'(b)};
        b0.ps2_mouse = pm;
        b1.ps2_mouse = pm;
        b0.ps2_wheel = wl;
        b1.ps2_wheel = wl;
        @(posedge clk_sys);
        #1;
        model_pkt(0, dx, dy, b, w);
        model_pkt(1, dx, dy, b, w);
    endtask

    logic [7:0] e0, e1;

    task automatic rd_start(output logic [7:0] g0, output logic [7:0] g1);
        @(negedge clk_sys);
        set_sel(1'b1);
        @(posedge clk_sys);
        #1;
        e0 = 8'(model_start(0));
        e1 = 8'(model_start(1));
        g0 = b0.dout;
        g1 = b1.dout;
        chk("rd_d0", g0, e0);
        chk("rd_d1", g1, e1);
    endtask

    task automatic rd_end();
        @(negedge clk_sys);
        set_sel(1'b0);
        @(posedge clk_sys);
        #1;
        model_retire(0);
        model_retire(1);
        chk("idle_d0", b0.dout, 8'hFF);
        chk("idle_d1", b1.dout, 8'hFF);
    endtask

    task automatic rd(int hold, output logic [7:0] g0, output logic [7:0] g1);
        rd_start(g0, g1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_sys);
            #1;
            chk("hold_d0", b0.dout, e0);
            chk("hold_d1", b1.dout, e1);
        end
        rd_end();
    endtask

    logic [7:0] g0, g1;
    int last_b;

    initial begin
        b0.ps2_mouse = '0;
        b1.ps2_mouse = '0;
        b0.ps2_wheel = '0;
        b1.ps2_wheel = '0;
        set_sel(1'b0);
        model_reset();
        do_reset();

        // single packet: X, Y, button, then empty
        packet(5, -3, 1, 0);
        rd(0, g0, g1); chk("t1_x", g0, 8'h45);
        rd(1, g0, g1); chk("t1_y", g0, 8'hBD);
        rd(0, g0, g1); chk("t1_btn", g0, 8'hC1);
        rd(0, g0, g1); chk("t1_empty", g0, 8'h00);

        // large X drained in clamped slices
        do_reset();
        repeat (3) packet(100, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            rd(0, g0, g1);
            chk("t2_slice", g0, 8'h5F);
        end
        rd(0, g0, g1); chk("t2_rem", g0, 8'h55);
        rd(0, g0, g1); chk("t2_empty", g0, 8'h00);

        // saturation on the narrow instance
        do_reset();
        repeat (10) packet(-255, 0, 0, 0);
        rd(0, g0, g1); chk("t3_sat", g1, 8'h60);
        rd(0, g0, g1); chk("t3_next", g1, 8'h60);

        // round-robin between X and Y
        do_reset();
        packet(100, -100, 0, 0);
        packet(100, 0, 0, 0);
        rd(0, g0, g1); chk("t4_x", g0, 8'h5F);
        rd(0, g0, g1); chk("t4_y", g0, 8'hA0);
        for (int i = 0; i < 11; i++) rd(0, g0, g1);
        chk("t4_done", g0, 8'h00);

        // packet arriving during a held read is preserved
        do_reset();
        packet(40, 0, 0, 0);
        rd_start(g0, g1); chk("t5_x", g0, 8'h5F);
        packet(10, 0, 0, 0);
        chk("t5_hold", b0.dout, 8'h5F);
        rd_end();
        rd(0, g0, g1); chk("t5_rest", g0, 8'h53);

        // wheel record, tied-off wheel on the narrow instance
        do_reset();
        packet(0, 0, 0, -3);
        rd(0, g0, g1);
        chk("t6_whl", g0, 8'hED);
        chk("t6_nowhl", g1, 8'h00);
        rd(0, g0, g1); chk("t6_empty", g0, 8'h00);

        // reset while a read is in progress
        packet(5, 0, 0, 0);
        rd_start(g0, g1);
        @(negedge clk_sys);
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        model_reset();
        chk("t7_rst", b0.dout, 8'hFF);
        @(negedge clk_sys);
        reset = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("t7_held", b0.dout, 8'hFF);
        @(negedge clk_sys);
        set_sel(1'b0);
        @(posedge clk_sys);
        #1;
        rd(0, g0, g1); chk("t7_empty", g0, 8'h00);

        // randomized traffic against the model
        do_reset();
        last_b = 0;
        for (int it = 0; it < 300; it++) begin
            int r = int'($urandom_range(9));
            if (r < 4) begin
                int dx = (r == 0) ? int'($urandom_range(511)) - 256
                                  : int'($urandom_range(80)) - 40;
                int dy = int'($urandom_range(80)) - 40;
                int w  = int'($urandom_range(8)) - 4;
                if ($urandom_range(3) == 0)
                    last_b = int'($urandom_range(7));
                packet(dx, dy, last_b, w);
            end else if (r == 4) begin
                rd_start(g0, g1);
                packet(int'($urandom_range(20)) - 10,
                       int'($urandom_range(20)) - 10, last_b, 1);
                rd_end();
            end else begin
                rd(int'($urandom_range(2)), g0, g1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
